dcache_refill_ctrl: RTL
=======================

Name: dcache_refill_ctrl

Overview:
- Miss handler on the d_cache side of memory_arbiter; the initiator end of the arbiter's d_cache port.
- Accepts one miss at a time from the d_cache and, if the victim line is dirty, writes it back.
- Then reads the missing line and returns it to the cache with a one-cycle fill pulse.
- Drives address/in_data/write_or_read/enable into the arbiter and consumes out_data/ready.

Parameters:
- LINE_WIDTH, `LINE_WIDTH (128): cache line width in bits; also arbiter data width.
- ADDR_SIZE, `PHYS_ADDR_SIZE (20): physical address width.
- OFFSET_BITS, $clog2(LINE_WIDTH/8) (4): byte-offset bits cleared to line-align addresses.
- TIMEOUT_CYCLES, 255: watchdog limit; used only with REFILL_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- miss_valid  in  1  cache presents a miss.
- miss_ready  out  1  controller idle; miss accepted on a cycle where miss_valid and miss_ready are both 1.
- miss_addr  in  ADDR_SIZE  address of the missing line.
- miss_dirty  in  1  victim needs write-back.
- victim_addr  in  ADDR_SIZE  victim line address.
- victim_data  in  LINE_WIDTH  victim line data.
- fill_valid  out  1  one-cycle pulse; fill_data/fill_addr valid.
- fill_addr  out  ADDR_SIZE  line-aligned address of the filled line.
- fill_data  out  LINE_WIDTH  line read from memory.
- fill_error  out  1  one-cycle pulse, timeout abort (0 without macro).
- error_sticky  out  1  set by a timeout, cleared only by reset (0 without macro).
- last_latency  out  16  cycles outside IDLE for the last completed miss; saturating.
- mem_address  out  ADDR_SIZE  to arbiter d_cache_address.
- mem_in_data  out  LINE_WIDTH  to arbiter d_cache_in_data.
- mem_write_or_read  out  1  1 = write, 0 = read.
- mem_enable  out  1  request strobe.
- mem_out_data  in  LINE_WIDTH  from arbiter d_cache_out_data.
- mem_ready  in  1  from arbiter d_cache_ready.

Behaviour:
- Reset values (reset=0, asynchronous):
  - state IDLE; miss_ready=1.
  - All other outputs 0, including mem_enable, fill_valid, error_sticky and last_latency.
- Asserting reset mid-operation aborts immediately. mem_enable drops the same instant, no fill_valid is produced, and latched data is discarded.
- Register outputs; no combinational path from mem_ready to mem_enable.
- Arbiter handshake:
  - mem_enable is held high with address, data and direction stable until mem_ready is sampled 1.
  - mem_out_data is captured on the cycle mem_ready=1.
  - mem_enable is then low for at least one cycle before the next request.
- States:
  - IDLE: miss_ready=1. On accept, latch all miss inputs with the low OFFSET_BITS cleared, and clear the latency counter.
    - miss_dirty=1 -> WB_REQ.
    - miss_dirty=0 -> FILL_REQ.
  - WB_REQ: mem_enable=1, write_or_read=1, address=victim_addr, in_data=victim_data. On mem_ready -> WB_GAP.
  - WB_GAP: one cycle with mem_enable=0 -> FILL_REQ.
  - FILL_REQ: mem_enable=1, write_or_read=0, address=miss_addr. On mem_ready, capture mem_out_data -> DONE.
  - DONE: fill_valid=1 for exactly one cycle, and last_latency is updated -> IDLE.
- miss_ready=0 in every state except IDLE; miss_valid asserted while busy is ignored.
- A new miss may be accepted on the cycle after DONE.
- Latency counter:
  - Increments every non-IDLE cycle and saturates at 0xFFFF.
  - Clean miss with zero-wait ready: 2.
  - Clean miss with ready in the 3rd enable cycle: 4.
- mem_ready arriving while mem_enable=0 is ignored.

Optional Feature:
- Macro REFILL_TIMEOUT_EN.
  - Defined: a cycle counter runs in WB_REQ and FILL_REQ and reloads on every request.
    - After TIMEOUT_CYCLES enable cycles without mem_ready, mem_enable drops and the FSM returns to IDLE.
    - fill_error pulses one cycle; error_sticky is set; fill_valid is not asserted; last_latency is updated.
  - Undefined: the FSM waits indefinitely, and fill_error and error_sticky are tied 0.
- The port list is identical in both builds.

Decomposition:
- Shared include (memory/preprocessor_directives.v):
  - LINE_WIDTH and PHYS_ADDR_SIZE.
  - State encodings: IDLE=0, WB_REQ=1, WB_GAP=2, FILL_REQ=3, DONE=4 (3 bits).
  - Write/read encoding constants.
- One natural sub-module: refill_timer, holding the saturating latency counter plus the watchdog compare enabled by REFILL_TIMEOUT_EN.

Test Plan:
- Clean miss: miss_addr=0x01234, dirty=0; memory ready on the 3rd enable cycle with 128'hDEAD_BEEF_...
  - Requires mem_address=0x01230 and write_or_read=0.
  - Requires one fill_valid pulse with fill_addr=0x01230, matching data, and last_latency=4.
- Dirty miss: victim_addr=0x00A48 with data 128'h55..55, miss_addr=0x00B00.
  - Requires a write to 0x00A40 carrying that data, then exactly one enable-low cycle.
  - Then a read from 0x00B00 and fill_valid.
- Busy: a second miss_valid (0x02000) during FILL_REQ.
  - Requires miss_ready=0 and no second memory request until after DONE.
- Reset asserted during FILL_REQ: mem_enable=0 at once, fill_valid never pulses, and all outputs are at reset values.
- Zero-wait: mem_ready=1 on the first enable cycle of a clean miss.
  - Requires fill_valid on the next cycle and last_latency=2.
- With REFILL_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready held 0.
  - Requires mem_enable to drop after 8 cycles, one fill_error pulse, error_sticky=1, and miss_ready=1.

Source files
------------

// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared constants for the d_cache refill path: line/address widths,
// refill FSM state encoding and arbiter direction encoding.
package dcache_refill_ctrl_pkg;

    localparam int LINE_WIDTH     = 128;
    localparam int PHYS_ADDR_SIZE = 20;
    localparam int LAT_W          = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WB_REQ   = 3'd1,
        WB_GAP   = 3'd2,
        FILL_REQ = 3'd3,
        DONE     = 3'd4
    } refill_state_t;

    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ  = 1'b0;

endpackage

// File: rtl/dcache_refill_ctrl_timer.sv
// Saturating per-miss latency counter and optional request watchdog.
// Watchdog compiled in only with REFILL_TIMEOUT_EN.
module refill_timer
    import dcache_refill_ctrl_pkg::*;
#(
`ifdef REFILL_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 255,
`endif
    parameter int CNT_W = LAT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             busy,
    input  logic             done_evt,
`ifdef REFILL_TIMEOUT_EN
    input  logic             req_active,
    input  logic             mem_ready,
    output logic             timeout,
`endif
    output logic [CNT_W-1:0] last_latency
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] lat_inc;

    assign lat_inc = (lat_cnt == CNT_MAX) ? CNT_MAX : lat_cnt + 1'b1;

    // Count busy cycles since the miss was accepted, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_cnt <= '0;
        end else if (start) begin
            lat_cnt <= '0;
        end else if (busy) begin
            lat_cnt <= lat_inc;
        end
    end

    // Publish the count including the finishing cycle itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_latency <= '0;
        end else if (done_evt) begin
            last_latency <= lat_inc;
        end
    end

`ifdef REFILL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    // Enable cycles of the current request; cleared between requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (req_active) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign timeout = req_active && !mem_ready && (wd_cnt == WD_LAST);
`endif

endmodule

// File: rtl/dcache_refill_ctrl.sv
// d_cache miss handler: optional victim write-back, then line fill.
// Optional watchdog abort: define REFILL_TIMEOUT_EN.
module dcache_refill_ctrl
    import dcache_refill_ctrl_pkg::*;
#(
    parameter int LINE_WIDTH     = dcache_refill_ctrl_pkg::LINE_WIDTH,
    parameter int ADDR_SIZE      = PHYS_ADDR_SIZE,
    parameter int OFFSET_BITS    = $clog2(LINE_WIDTH / 8),
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_SIZE-1:0]  miss_addr,
    input  logic                  miss_dirty,
    input  logic [ADDR_SIZE-1:0]  victim_addr,
    input  logic [LINE_WIDTH-1:0] victim_data,
    output logic                  fill_valid,
    output logic [ADDR_SIZE-1:0]  fill_addr,
    output logic [LINE_WIDTH-1:0] fill_data,
    output logic                  fill_error,
    output logic                  error_sticky,
    output logic [15:0]           last_latency,
    output logic [ADDR_SIZE-1:0]  mem_address,
    output logic [LINE_WIDTH-1:0] mem_in_data,
    output logic                  mem_write_or_read,
    output logic                  mem_enable,
    input  logic [LINE_WIDTH-1:0] mem_out_data,
    input  logic                  mem_ready
);

    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK =
        {{(ADDR_SIZE - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    refill_state_t state_q;
    refill_state_t state_d;

    logic                  accept;
    logic                  req_active;
    logic                  timeout;
    logic [ADDR_SIZE-1:0]  miss_addr_q;
    logic [ADDR_SIZE-1:0]  victim_addr_q;
    logic [LINE_WIDTH-1:0] victim_data_q;
    logic [LINE_WIDTH-1:0] fill_data_q;

    // State register; reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_d           = state_q;
        accept            = 1'b0;
        miss_ready        = 1'b0;
        mem_enable        = 1'b0;
        mem_write_or_read = MEM_READ;
        fill_valid        = 1'b0;
        req_active        = 1'b0;
        unique case (state_q)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    accept  = 1'b1;
                    state_d = miss_dirty ? WB_REQ : FILL_REQ;
                end
            end
            WB_REQ: begin
                mem_enable        = 1'b1;
                mem_write_or_read = MEM_WRITE;
                req_active        = 1'b1;
                if (mem_ready) begin
                    state_d = WB_GAP;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            WB_GAP: begin
                state_d = FILL_REQ;
            end
            FILL_REQ: begin
                mem_enable = 1'b1;
                req_active = 1'b1;
                if (mem_ready) begin
                    state_d = DONE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                fill_valid = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the line-aligned miss request on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_addr_q   <= '0;
            victim_addr_q <= '0;
            victim_data_q <= '0;
        end else if (accept) begin
            miss_addr_q   <= miss_addr & ALIGN_MASK;
            victim_addr_q <= victim_addr & ALIGN_MASK;
            victim_data_q <= victim_data;
        end
    end

    // Capture the returned line on the read handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_data_q <= '0;
        end else if (state_q == FILL_REQ && mem_ready) begin
            fill_data_q <= mem_out_data;
        end
    end

    assign mem_address = (state_q == WB_REQ) ? victim_addr_q : miss_addr_q;
    assign mem_in_data = victim_data_q;
    assign fill_addr   = miss_addr_q;
    assign fill_data   = fill_data_q;

    refill_timer #(
`ifdef REFILL_TIMEOUT_EN
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
`endif
        .CNT_W          (16)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .start        (accept),
        .busy         (state_q != IDLE),
        .done_evt     ((state_q == DONE) || timeout),
`ifdef REFILL_TIMEOUT_EN
        .req_active   (req_active),
        .mem_ready    (mem_ready),
        .timeout      (timeout),
`endif
        .last_latency (last_latency)
    );

`ifdef REFILL_TIMEOUT_EN
    logic fill_error_q;
    logic error_sticky_q;

    // Abort reporting: one-cycle pulse plus a flag held until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_error_q   <= 1'b0;
            error_sticky_q <= 1'b0;
        end else begin
            fill_error_q   <= timeout;
            error_sticky_q <= error_sticky_q | timeout;
        end
    end

    assign fill_error   = fill_error_q;
    assign error_sticky = error_sticky_q;
`else
    assign timeout      = 1'b0;
    assign fill_error   = 1'b0;
    assign error_sticky = 1'b0;
`endif

endmodule
